// File: rtl/temp_servo_pkg.sv
// Shared definitions for the temperature servo blocks.
//   state_e   : PWM stage FSM encoding
//   DUTY_FULL : full-scale duty count, shared with the startup ramp
package temp_servo_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int DUTY_FULL = 100000;

endpackage

// File: rtl/temp_servo_duty_clamp.sv
// Duty request stage: optional PID add, clamp to [0, PERIOD], minimum-pulse
// shaping, one register stage.
//   clk, rst_n      : clock, async active-low reset
//   pid_en_i        : add pid_i to prst_i when high
//   prst_i, pid_i   : signed preset and correction
//   req_o           : shaped duty request (registered)
//   sat_hi_o/lo_o   : request was clamped to PERIOD / to 0 (registered)
module temp_servo_duty_clamp
  import temp_servo_pkg::*;
#(
  parameter int SIGSIZE  = 18,
  parameter int PERIOD   = DUTY_FULL,
  parameter int MINPULSE = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pid_en_i,
  input  logic [SIGSIZE-1:0] prst_i,
  input  logic [SIGSIZE-1:0] pid_i,
  output logic [SIGSIZE-1:0] req_o,
  output logic               sat_hi_o,
  output logic               sat_lo_o
);

  localparam logic signed [SIGSIZE:0] ZERO_S = '0;
  localparam logic signed [SIGSIZE:0] PER_S  = (SIGSIZE+1)'(PERIOD);
  localparam logic signed [SIGSIZE:0] MIN_S  = (SIGSIZE+1)'(MINPULSE);
  localparam logic signed [SIGSIZE:0] TOP_S  = (SIGSIZE+1)'(PERIOD - MINPULSE);

  logic signed [SIGSIZE:0] sum;
  logic signed [SIGSIZE:0] clamped;
  logic signed [SIGSIZE:0] shaped;
  logic [SIGSIZE-1:0]      req_d, req_q;
  logic                    sat_hi_d, sat_hi_q;
  logic                    sat_lo_d, sat_lo_q;

  // One extra bit of headroom means the add can never wrap.
  always_comb begin
    sum = $signed({prst_i[SIGSIZE-1], prst_i});
    if (pid_en_i) sum = sum + $signed({pid_i[SIGSIZE-1], pid_i});

    sat_lo_d = sum[SIGSIZE];
    sat_hi_d = !sat_lo_d && (sum > PER_S);

    if (sat_lo_d)      clamped = ZERO_S;
    else if (sat_hi_d) clamped = PER_S;
    else               clamped = sum;

    // Pulses shorter than MINPULSE (high or low) are squeezed out.
    shaped = clamped;
    if ((clamped > ZERO_S) && (clamped < MIN_S))      shaped = ZERO_S;
    else if ((clamped > TOP_S) && (clamped < PER_S))  shaped = PER_S;

    req_d = shaped[SIGSIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
    end else begin
      req_q    <= req_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign req_o    = req_q;
  assign sat_hi_o = sat_hi_q;
  assign sat_lo_o = sat_lo_q;

endmodule

// File: rtl/temp_servo_pwm.sv
// Heater PWM output stage. Duty requests are double-buffered into a shadow
// register that only updates at period boundaries, so pwm is glitch-free.
//   clk, rst_n     : clock, async active-low reset
//   on             : servo enable; low forces OFF immediately on next edge
//   PID_EN         : add pid_out to prst
//   prst, pid_out  : signed preset / correction
//   pwm            : heater drive
//   duty_applied   : shadow duty in use this period
//   period_strobe  : high in the cycle cnt == 0 while running
//   sat_hi, sat_lo : request clamp flags
//
// state   | meaning
// --------+---------------------------------------------------
// ST_OFF  | idle, cnt/shadow/pwm held at 0, wait for on
// ST_LOAD | one cycle: load shadow from req, clear cnt
// ST_RUN  | count 0..PERIOD-1, reload shadow at each wrap
module temp_servo_pwm
  import temp_servo_pkg::*;
#(
  parameter int SIGSIZE  = 18,
  parameter int PERIOD   = DUTY_FULL,
  parameter int MINPULSE = 100,
  parameter int CNTW     = $clog2(PERIOD)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on,
  input  logic               PID_EN,
  input  logic [SIGSIZE-1:0] prst,
  input  logic [SIGSIZE-1:0] pid_out,
  output logic               pwm,
  output logic [SIGSIZE-1:0] duty_applied,
  output logic               period_strobe,
  output logic               sat_hi,
  output logic               sat_lo
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PERIOD - 1);

  state_e             state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [SIGSIZE-1:0] shadow_q;
  logic [SIGSIZE-1:0] req;
  logic               pwm_q;
  logic               strobe_q;

  temp_servo_duty_clamp #(
    .SIGSIZE  (SIGSIZE),
    .PERIOD   (PERIOD),
    .MINPULSE (MINPULSE)
  ) u_clamp (
    .clk      (clk),
    .rst_n    (rst_n),
    .pid_en_i (PID_EN),
    .prst_i   (prst),
    .pid_i    (pid_out),
    .req_o    (req),
    .sat_hi_o (sat_hi),
    .sat_lo_o (sat_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else if (!on) begin
      // Safety: abandon the current pulse, wrap reload is also suppressed.
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_q  <= ST_LOAD;
          cnt_q    <= '0;
          shadow_q <= '0;
          pwm_q    <= 1'b0;
          strobe_q <= 1'b0;
        end
        ST_LOAD: begin
          state_q  <= ST_RUN;
          cnt_q    <= '0;
          shadow_q <= req;
          pwm_q    <= 1'b0;
          strobe_q <= 1'b1;
        end
        ST_RUN: begin
          // Compare uses the current cnt/shadow pair, so the last clock of a
          // full-duty period stays high across the wrap.
          pwm_q <= (SIGSIZE'(cnt_q) < shadow_q);
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            shadow_q <= req;
            strobe_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            strobe_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_OFF;
          cnt_q    <= '0;
          shadow_q <= '0;
          pwm_q    <= 1'b0;
          strobe_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwm           = pwm_q;
  assign duty_applied  = shadow_q;
  assign period_strobe = strobe_q;

endmodule

// File: tb/tb_temp_servo_pwm.sv
module tb_temp_servo_pwm;
  import temp_servo_pkg::*;

  localparam int S  = 18;
  localparam int P  = 1000;
  localparam int MP = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         on;
  logic         PID_EN;
  logic [S-1:0] prst;
  logic [S-1:0] pid_out;
  logic         pwm;
  logic [S-1:0] duty_applied;
  logic         period_strobe;
  logic         sat_hi;
  logic         sat_lo;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  temp_servo_pwm #(.SIGSIZE(S), .PERIOD(P), .MINPULSE(MP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .on            (on),
    .PID_EN        (PID_EN),
    .prst          (prst),
    .pid_out       (pid_out),
    .pwm           (pwm),
    .duty_applied  (duty_applied),
    .period_strobe (period_strobe),
    .sat_hi        (sat_hi),
    .sat_lo        (sat_lo)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: integer arithmetic straight from the duty rules.
  function automatic void model(input int pr, input int pd, input bit en,
                                output int duty, output bit shi, output bit slo);
    int s;
    s    = en ? pr + pd : pr;
    slo  = (s < 0);
    shi  = (s > P);
    duty = slo ? 0 : (shi ? P : s);
    if (duty > 0 && duty < MP)         duty = 0;
    else if (duty > P - MP && duty < P) duty = P;
  endfunction

  // Count high pwm clocks over one period. pwm lags cnt by one clock, so the
  // window is the P samples after a strobe cycle, ending on the next strobe.
  task automatic measure(input bit wait_first, output int highs, output int duty_seen);
    int n;
    int stray;
    if (wait_first) begin
      n = 0;
      @(negedge clk);
      while (!period_strobe && n < 3 * P) begin
        @(negedge clk);
        n++;
      end
      if (!period_strobe) check("strobe_timeout", 0, 1);
    end
    duty_seen = 32'(duty_applied);
    highs = 0;
    stray = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      highs += 32'(pwm);
      if (i < P - 1 && period_strobe) stray++;
    end
    check("strobe_stray", stray, 0);
    check("period_len", 32'(period_strobe), 1);
  endtask

  task automatic apply(input string tag, input int pr, input int pd, input bit en);
    int ed, hi, dseen;
    bit eshi, eslo;
    model(pr, pd, en, ed, eshi, eslo);
    prst    = S'(pr);
    pid_out = S'(pd);
    PID_EN  = en;
    @(negedge clk);
    check({tag, "_sat_hi"}, 32'(sat_hi), 32'(eshi));
    check({tag, "_sat_lo"}, 32'(sat_lo), 32'(eslo));
    measure(1'b1, hi, dseen);
    check({tag, "_duty"}, dseen, ed);
    check({tag, "_highs"}, hi, ed);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pwm"},    32'(pwm), 0);
    check({tag, "_strobe"}, 32'(period_strobe), 0);
    check({tag, "_duty"},   32'(duty_applied), 0);
    check({tag, "_sat_hi"}, 32'(sat_hi), 0);
    check({tag, "_sat_lo"}, 32'(sat_lo), 0);
  endtask

  initial begin
    int hi, dseen, pr, pd;
    bit en;

    rst_n = 1'b0; on = 1'b0; PID_EN = 1'b0; prst = '0; pid_out = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("off_idle_pwm", 32'(pwm), 0);

    // 1: plain preset 250, first strobe two edges after on
    prst = S'(250);
    on   = 1'b1;
    @(negedge clk);
    check("s1_load_strobe", 32'(period_strobe), 0);
    @(negedge clk);
    check("s1_first_strobe", 32'(period_strobe), 1);
    check("s1_first_duty", 32'(duty_applied), 250);
    @(negedge clk);
    check("s1_first_pwm", 32'(pwm), 1);
    measure(1'b1, hi, dseen);
    check("s1_highs_a", hi, 250);
    measure(1'b0, hi, dseen);
    check("s1_highs_b", hi, 250);
    check("s1_duty", dseen, 250);

    // 2: saturation high across several wraps, then saturation low
    apply("s2_hi", 900, 300, 1'b1);
    measure(1'b0, hi, dseen);
    check("s2_hi_wrap2", hi, P);
    measure(1'b0, hi, dseen);
    check("s2_hi_wrap3", hi, P);
    apply("s2_lo", 900, -1000, 1'b1);

    // 3: minimum pulse boundaries
    apply("mp5",   5,   0, 1'b0);
    apply("mp995", 995, 0, 1'b0);
    apply("mp10",  10,  0, 1'b0);
    apply("mp990", 990, 0, 1'b0);
    apply("mp9",   9,   0, 1'b0);
    apply("mp991", 991, 0, 1'b0);
    apply("neg1",  -1,  0, 1'b0);

    // randomized requests against the model
    for (int k = 0; k < 6; k++) begin
      pr = int'($urandom_range(1500)) - 200;
      pd = int'($urandom_range(1200)) - 600;
      en = 1'($urandom_range(1));
      apply($sformatf("rnd%0d", k), pr, pd, en);
    end

    // 4: request change mid-period must not affect the running period
    apply("s4_pre", 250, 0, 1'b0);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      hi += 32'(pwm);
      if (i == 399) prst = S'(600);
    end
    check("s4_cur_highs", hi, 250);
    check("s4_cur_len", 32'(period_strobe), 1);
    measure(1'b0, hi, dseen);
    check("s4_next_highs", hi, 600);
    check("s4_next_duty", dseen, 600);

    // 5: on dropped mid-pulse
    apply("s5_pre", 500, 0, 1'b0);
    repeat (100) @(negedge clk);
    check("s5_pwm_before", 32'(pwm), 1);
    on = 1'b0;
    @(negedge clk);
    check("s5_pwm_off", 32'(pwm), 0);
    check("s5_duty_off", 32'(duty_applied), 0);
    check("s5_state", 32'(dut.state_q), 32'(ST_OFF));
    check("s5_cnt", 32'(dut.cnt_q), 0);
    repeat (3) @(negedge clk);
    check("s5_pwm_stays", 32'(pwm), 0);
    on = 1'b1;
    @(negedge clk);
    check("s5_load_strobe", 32'(period_strobe), 0);
    @(negedge clk);
    check("s5_restart_strobe", 32'(period_strobe), 1);
    check("s5_restart_duty", 32'(duty_applied), 500);
    @(negedge clk);
    check("s5_restart_pwm", 32'(pwm), 1);

    // 6: asynchronous reset mid-RUN while saturated high
    apply("s6_pre", 1200, 0, 1'b0);
    repeat (50) @(negedge clk);
    check("s6_pwm_before", 32'(pwm), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("s6_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("s6_held");
    rst_n = 1'b1;
    @(negedge clk);
    check("s6_load_strobe", 32'(period_strobe), 0);
    check("s6_sat_hi", 32'(sat_hi), 1);
    @(negedge clk);
    check("s6_restart_strobe", 32'(period_strobe), 1);
    check("s6_restart_duty", 32'(duty_applied), P);
    @(negedge clk);
    check("s6_restart_pwm", 32'(pwm), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
